// File: rtl/uart_tx_pll_gated.sv
// uart_tx_pll_gated
// Byte-wide UART transmitter running on the 1 MHz PLL output clock. The line
// stays idle-high until the PLL lock flag has been stable for LOCK_WAIT cycles.
// Losing lock at any point returns the block to WAIT_LOCK and drops the frame.
//
// Handshake: a byte is transferred on a refclk edge where tx_valid and tx_ready
// are both high. tx_ready is registered and is high only in IDLE. tx_valid is
// ignored while tx_ready is low. tx_data is sampled only at the transfer edge.
module uart_tx_pll_gated #(
  parameter int CLK_HZ    = 1000000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LOCK_WAIT = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       abort
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LOCK_W       = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WAIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_PAR       = 3'd4;
  localparam logic [2:0] ST_STOP      = 3'd5;

  logic              sync_q;
  logic              lk_s;
  logic [2:0]        state;
  logic [LOCK_W-1:0] lock_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Two-flop synchroniser bringing the asynchronous lock flag into refclk.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= 1'b0;
      lk_s   <= 1'b0;
    end else begin
      sync_q <= pll_locked;
      lk_s   <= sync_q;
    end
  end

  // Transmit FSM; every output is a register updated alongside the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= ST_WAIT_LOCK;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      abort    <= 1'b0;
      lock_cnt <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      abort <= 1'b0;
      if ((state != ST_WAIT_LOCK) && !lk_s) begin
        // Lock loss overrides everything, including a byte offered in IDLE.
        state    <= ST_WAIT_LOCK;
        tx       <= 1'b1;
        tx_ready <= 1'b0;
        busy     <= 1'b0;
        lock_cnt <= '0;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        abort    <= (state != ST_IDLE);
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            if (lk_s) begin
              if (lock_cnt == LOCK_LAST) begin
                state    <= ST_IDLE;
                tx_ready <= 1'b1;
                lock_cnt <= '0;
              end else begin
                lock_cnt <= lock_cnt + 1'b1;
              end
            end else begin
              lock_cnt <= '0;
            end
          end
          ST_IDLE: begin
            if (tx_valid && tx_ready) begin
              shreg    <= tx_data;
              par_bit  <= (PARITY == 2) ? ~(^tx_data) : (^tx_data);
              state    <= ST_START;
              tx       <= 1'b0;
              busy     <= 1'b1;
              tx_ready <= 1'b0;
              baud_cnt <= '0;
            end
          end
          ST_START: begin
            if (baud_done) begin
              state    <= ST_DATA;
              tx       <= shreg[0];
              baud_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (baud_done) begin
              baud_cnt <= '0;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (PARITY != 0) begin
                  state <= ST_PAR;
                  tx    <= par_bit;
                end else begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
                end
              end else begin
                // shreg[0] is always the bit on the line; shift in the next one.
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {1'b0, shreg[7:1]};
                tx      <= shreg[1];
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          ST_PAR: begin
            if (baud_done) begin
              state    <= ST_STOP;
              tx       <= 1'b1;
              baud_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (baud_done) begin
              baud_cnt <= '0;
              // bit_cnt counts stop-bit periods so two stop bits reuse the baud wrap.
              if (bit_cnt == STOP_LAST) begin
                state    <= ST_IDLE;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                bit_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: begin
            state    <= ST_WAIT_LOCK;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            lock_cnt <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_pll_gated.sv
// Testbench for uart_tx_pll_gated: four instances cover no parity, even, odd
// and even with two stop bits. A scoreboard checks every transmitted frame.
`timescale 1ns/1ps
module tb_uart_tx_pll_gated;

  localparam int CPB = 1000000 / 9600;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic [7:0] tx_data;
  logic [3:0] tx_valid_v;
  logic [3:0] tx_ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] abort_v;

  int par_cfg[4]  = '{0, 1, 2, 1};
  int stop_cfg[4] = '{1, 1, 1, 2};

  logic [1:0] sel;
  logic       m_tx, m_busy, m_ready, m_abort;
  assign m_tx    = tx_v[sel];
  assign m_busy  = busy_v[sel];
  assign m_ready = tx_ready_v[sel];
  assign m_abort = abort_v[sel];

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];
  int         len_q[$];
  bit         mon_en = 1'b0;
  logic       prev_busy = 1'b0;
  int         busy_len = 0;

  // ---------------- clock / reset ----------------
  always #5 refclk = ~refclk;

  uart_tx_pll_gated u_dut0 (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .tx_data(tx_data),
    .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready_v[0]), .tx(tx_v[0]),
    .busy(busy_v[0]), .abort(abort_v[0])
  );

  uart_tx_pll_gated #(.PARITY(1)) u_dut_even (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .tx_data(tx_data),
    .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready_v[1]), .tx(tx_v[1]),
    .busy(busy_v[1]), .abort(abort_v[1])
  );

  uart_tx_pll_gated #(.PARITY(2)) u_dut_odd (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .tx_data(tx_data),
    .tx_valid(tx_valid_v[2]), .tx_ready(tx_ready_v[2]), .tx(tx_v[2]),
    .busy(busy_v[2]), .abort(abort_v[2])
  );

  uart_tx_pll_gated #(.PARITY(1), .STOP_BITS(2)) u_dut_even2 (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .tx_data(tx_data),
    .tx_valid(tx_valid_v[3]), .tx_ready(tx_ready_v[3]), .tx(tx_v[3]),
    .busy(busy_v[3]), .abort(abort_v[3])
  );

  // ---------------- scoreboard ----------------
  // Samples each bit period at its midpoint and checks the busy length at its end.
  always @(posedge refclk) begin
    logic [0:0] eb;
    int         el;
    #1;
    if (mon_en) begin
      if (m_busy === 1'b1) begin
        if (prev_busy !== 1'b1) busy_len = 0;
        if ((busy_len % CPB) == CPB / 2) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_bit: unexpected bit at busy cycle %0d, tx=%b, no bit expected", busy_len, m_tx);
          end else begin
            eb = exp_q.pop_front();
            if (m_tx !== eb[0]) begin
              n_fail++;
              $display("FAIL sb_bit: busy cycle %0d tx=%b expected %b", busy_len, m_tx, eb[0]);
            end
          end
        end
        busy_len++;
      end else if (prev_busy === 1'b1) begin
        n_checks++;
        if (len_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_len: unexpected frame of %0d busy cycles", busy_len);
        end else begin
          el = len_q.pop_front();
          if (busy_len != el) begin
            n_fail++;
            $display("FAIL sb_len: busy lasted %0d cycles expected %0d", busy_len, el);
          end
        end
      end
    end
    prev_busy = m_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge refclk);
    #2;
  endtask

  // Reference frame model: start, 8 data bits LSB first, optional parity, stop bits.
  function automatic void push_frame(input logic [7:0] d, input int par, input int sb);
    logic [0:0] b;
    b = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
      b[0] = d[i];
      exp_q.push_back(b);
    end
    if (par != 0) begin
      b[0] = (par == 2) ? ~(^d) : (^d);
      exp_q.push_back(b);
    end
    for (int i = 0; i < sb; i++) begin
      b = 1'b1;
      exp_q.push_back(b);
    end
    len_q.push_back((9 + ((par != 0) ? 1 : 0) + sb) * CPB);
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (m_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    n_checks++;
    if (m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: tx_ready=%b after %0d cycles, expected 1", name, m_ready, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit track);
    wait_ready("send");
    tx_data = d;
    if (track) push_frame(d, par_cfg[sel], stop_cfg[sel]);
    tx_valid_v[sel] = 1'b1;
    tick();
    tx_valid_v[sel] = 1'b0;
    tx_data = ~d;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", name, m_busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    tx_valid_v = '0;
    tx_data = 8'h00;
    sel = 2'd0;
    tick();
    tick();
    n_checks++;
    if (m_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", m_tx); end
    n_checks++;
    if (m_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", m_ready); end
    n_checks++;
    if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    n_checks++;
    if (m_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b expected 0", m_abort); end
  endtask

  task automatic test_lock_wait();
    int bad;
    bad = 0;
    rst = 1'b0;
    pll_locked = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k < 18 && (tx_ready_v !== 4'b0000 || tx_v !== 4'b1111)) bad++;
      if (k == 18) begin
        n_checks++;
        if (tx_ready_v !== 4'b1111) begin
          n_fail++;
          $display("FAIL lock_ready_rise: tx_ready=%b at cycle 18 expected 1111", tx_ready_v);
        end
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL lock_ready_low: %0d early/glitch cycles, expected 0", bad);
    end
  endtask

  task automatic test_frame_basic();
    sel = 2'd0;
    mon_en = 1'b1;
    send_byte(8'hA5, 1'b1);
    // Offers while busy must be ignored.
    repeat (200) tick();
    tx_data = 8'hFF;
    tx_valid_v[0] = 1'b1;
    repeat (20) tick();
    tx_valid_v[0] = 1'b0;
    wait_idle("a5");
    n_checks++;
    if (m_ready !== 1'b1 || m_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_after: ready=%b tx=%b expected 1 1", m_ready, m_tx);
    end
    for (int i = 0; i < 2; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      wait_idle("rand");
    end
    n_checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_drain: %0d bits %0d frames left, expected 0 0", exp_q.size(), len_q.size());
    end
  endtask

  task automatic test_parity();
    for (int s = 1; s <= 3; s++) begin
      sel = 2'(s);
      send_byte(8'h07, 1'b1);
      wait_idle("parity");
      n_checks++;
      if (m_ready !== 1'b1 || m_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_after_%0d: ready=%b busy=%b expected 1 0", s, m_ready, m_busy);
      end
    end
    sel = 2'd0;
    n_checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_drain: %0d bits %0d frames left, expected 0 0", exp_q.size(), len_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    sel = 2'd0;
    wait_ready("b2b");
    tx_data = 8'h55;
    push_frame(8'h55, 0, 1);
    tx_valid_v[0] = 1'b1;
    tick();
    tx_data = 8'hAA;
    push_frame(8'hAA, 0, 1);
    n = 0;
    while (m_busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    n_checks++;
    if (m_tx !== 1'b1 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: tx=%b ready=%b busy=%b expected 1 1 0", m_tx, m_ready, m_busy);
    end
    tick();
    tx_valid_v[0] = 1'b0;
    n_checks++;
    if (m_tx !== 1'b0 || m_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start: tx=%b busy=%b expected 0 1", m_tx, m_busy);
    end
    wait_idle("b2b");
    n_checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d bits %0d frames left, expected 0 0", exp_q.size(), len_q.size());
    end
  endtask

  task automatic test_abort();
    int abort_at, abort_cnt, bad;
    sel = 2'd0;
    mon_en = 1'b0;
    send_byte(8'hC3, 1'b0);
    repeat (4 * CPB + CPB / 2 - 2) tick();
    pll_locked = 1'b0;
    abort_at = 0;
    abort_cnt = 0;
    bad = 0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (m_abort === 1'b1) begin
        if (abort_at == 0) abort_at = t;
        abort_cnt++;
        if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_ready !== 1'b0) bad++;
      end
    end
    n_checks++;
    if (abort_at != 3) begin n_fail++; $display("FAIL abort_time: abort at cycle %0d expected 3", abort_at); end
    n_checks++;
    if (abort_cnt != 1) begin n_fail++; $display("FAIL abort_width: %0d cycles expected 1", abort_cnt); end
    n_checks++;
    if (bad != 0 || m_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_outputs: %0d bad cycles, tx=%b expected 0 and 1", bad, m_tx);
    end
    pll_locked = 1'b1;
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k < 18 && (m_ready !== 1'b0 || m_tx !== 1'b1)) bad++;
      if (k == 18) begin
        n_checks++;
        if (m_ready !== 1'b1) begin n_fail++; $display("FAIL relock_ready: got %b expected 1", m_ready); end
      end
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL relock_low: %0d bad cycles expected 0", bad); end
    mon_en = 1'b1;
    send_byte(8'h3C, 1'b1);
    wait_idle("relock");
    n_checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      n_fail++;
      $display("FAIL relock_drain: %0d bits %0d frames left, expected 0 0", exp_q.size(), len_q.size());
    end
  endtask

  task automatic test_reset_midframe(input int idx, input string name);
    int bad;
    sel = 2'd0;
    mon_en = 1'b0;
    send_byte(8'h96, 1'b0);
    repeat (idx) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (m_tx !== 1'b1 || m_ready !== 1'b0 || m_busy !== 1'b0 || m_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_reset: tx=%b ready=%b busy=%b abort=%b expected 1 0 0 0",
               name, m_tx, m_ready, m_busy, m_abort);
    end
    rst = 1'b0;
    bad = 0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_abort !== 1'b0) bad++;
      if (k < 18 && m_ready !== 1'b0) bad++;
      if (k == 18) begin
        n_checks++;
        if (m_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b expected 1", name, m_ready); end
      end
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL %s_no_resume: %0d bad cycles expected 0", name, bad); end
    mon_en = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_lock_wait();
    test_frame_basic();
    test_parity();
    test_back_to_back();
    test_abort();
    test_reset_midframe(9 * CPB + CPB / 2, "rst_stop");
    test_reset_midframe(3 * CPB + 20, "rst_data");
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    wait_idle("final");
    n_checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d bits %0d frames left, expected 0 0", exp_q.size(), len_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
